// File: rtl/riscv_pkg.sv
// Shared RV64 decode constants: opcodes, immediate formats and per-opcode register usage.
package riscv_pkg;

  localparam int XLEN = 64;

  localparam logic [6:0] OP_OP     = 7'b0110011;
  localparam logic [6:0] OP_OP_32  = 7'b0111011;
  localparam logic [6:0] OP_IMM    = 7'b0010011;
  localparam logic [6:0] OP_IMM_32 = 7'b0011011;
  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_JALR   = 7'b1100111;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_LUI    = 7'b0110111;
  localparam logic [6:0] OP_AUIPC  = 7'b0010111;
  localparam logic [6:0] OP_JAL    = 7'b1101111;

  typedef enum logic [2:0] {
    IMM_NONE,
    IMM_I,
    IMM_S,
    IMM_B,
    IMM_U,
    IMM_J
  } imm_fmt_e;

  typedef struct packed {
    logic     use_rs1;
    logic     use_rs2;
    logic     use_rd;
    logic     illegal;
    imm_fmt_e fmt;
  } dec_t;

  function automatic dec_t decode_op(input logic [6:0] op);
    dec_t d;
    d = '{use_rs1: 1'b0, use_rs2: 1'b0, use_rd: 1'b0, illegal: 1'b0, fmt: IMM_NONE};
    case (op)
      OP_OP, OP_OP_32:             d = '{1'b1, 1'b1, 1'b1, 1'b0, IMM_NONE};
      OP_IMM, OP_IMM_32, OP_LOAD,
      OP_JALR:                     d = '{1'b1, 1'b0, 1'b1, 1'b0, IMM_I};
      OP_STORE:                    d = '{1'b1, 1'b1, 1'b0, 1'b0, IMM_S};
      OP_BRANCH:                   d = '{1'b1, 1'b1, 1'b0, 1'b0, IMM_B};
      OP_LUI, OP_AUIPC:            d = '{1'b0, 1'b0, 1'b1, 1'b0, IMM_U};
      OP_JAL:                      d = '{1'b0, 1'b0, 1'b1, 1'b0, IMM_J};
      default:                     d = '{1'b0, 1'b0, 1'b0, 1'b1, IMM_NONE};
    endcase
    return d;
  endfunction

endpackage

// File: rtl/imm_gen_64.sv
// Combinational immediate generator: sign-extends the RV immediate of the given format to 64 bits.
module imm_gen_64
  import riscv_pkg::*;
(
  input  logic [31:0] instr,
  input  imm_fmt_e    fmt,
  output logic [63:0] imm
);

  always_comb begin
    imm = '0;
    case (fmt)
      IMM_I:   imm = {{52{instr[31]}}, instr[31:20]};
      IMM_S:   imm = {{52{instr[31]}}, instr[31:25], instr[11:7]};
      IMM_B:   imm = {{51{instr[31]}}, instr[31], instr[7], instr[30:25], instr[11:8], 1'b0};
      IMM_U:   imm = {{32{instr[31]}}, instr[31:12], 12'b0};
      IMM_J:   imm = {{43{instr[31]}}, instr[31], instr[19:12], instr[20], instr[30:21], 1'b0};
      default: imm = '0;
    endcase
  end

endmodule

// File: rtl/id_stage.sv
// Decode stage: single output register, register scoreboard for RAW/WAW interlock,
// same-cycle writeback bypass on operand capture.
module id_stage #(
  parameter int XLEN = riscv_pkg::XLEN
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [31:0]     in_instr,
  input  logic [XLEN-1:0] in_pc,
  output logic [4:0]      rd1_idx,
  output logic [4:0]      rd2_idx,
  input  logic [XLEN-1:0] rd1_data,
  input  logic [XLEN-1:0] rd2_data,
  input  logic            wb_valid,
  input  logic [4:0]      wb_idx,
  input  logic [XLEN-1:0] wb_data,
  input  logic            flush,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [XLEN-1:0] out_pc,
  output logic [31:0]     out_instr,
  output logic [XLEN-1:0] out_rs1_val,
  output logic [XLEN-1:0] out_rs2_val,
  output logic [XLEN-1:0] out_imm,
  output logic [4:0]      out_rd,
  output logic            out_wr_en,
  output logic            out_illegal
);
  import riscv_pkg::*;

  logic [31:0]     sb;
  dec_t            dec;
  logic [4:0]      rs1, rs2, rd;
  logic [XLEN-1:0] imm, rs1_val, rs2_val;
  logic [31:0]     clr_mask, set_mask, busy;
  logic            wb_clr, hazard, accept, wr_en;

  assign rs1     = in_instr[19:15];
  assign rs2     = in_instr[24:20];
  assign rd      = in_instr[11:7];
  assign rd1_idx = rs1;
  assign rd2_idx = rs2;
  assign dec     = decode_op(in_instr[6:0]);

  imm_gen_64 u_imm_gen (
    .instr (in_instr),
    .fmt   (dec.fmt),
    .imm   (imm)
  );

  // A bit being retired by writeback this cycle no longer blocks issue.
  assign wb_clr   = wb_valid && (wb_idx != 5'd0);
  assign clr_mask = wb_clr ? (32'd1 << wb_idx) : 32'd0;
  assign busy     = sb & ~clr_mask;
  assign hazard   = (dec.use_rs1 && busy[rs1]) ||
                    (dec.use_rs2 && busy[rs2]) ||
                    (dec.use_rd  && busy[rd]);

  assign in_ready = (!out_valid || out_ready) && !hazard && !flush && !reset;
  assign accept   = in_valid && in_ready;
  assign wr_en    = dec.use_rd && (rd != 5'd0);
  assign set_mask = (accept && wr_en) ? (32'd1 << rd) : 32'd0;

  assign rs1_val = (!dec.use_rs1 || rs1 == 5'd0) ? '0 :
                   (wb_clr && wb_idx == rs1)     ? wb_data : rd1_data;
  assign rs2_val = (!dec.use_rs2 || rs2 == 5'd0) ? '0 :
                   (wb_clr && wb_idx == rs2)     ? wb_data : rd2_data;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      sb          <= '0;
      out_valid   <= 1'b0;
      out_pc      <= '0;
      out_instr   <= '0;
      out_rs1_val <= '0;
      out_rs2_val <= '0;
      out_imm     <= '0;
      out_rd      <= '0;
      out_wr_en   <= 1'b0;
      out_illegal <= 1'b0;
    end else if (flush) begin
      sb        <= '0;
      out_valid <= 1'b0;
    end else begin
      // OR-ing the set mask last lets a same-index accept win over a writeback clear.
      sb <= (sb & ~clr_mask) | set_mask;
      if (accept) begin
        out_valid   <= 1'b1;
        out_pc      <= in_pc;
        out_instr   <= in_instr;
        out_rs1_val <= rs1_val;
        out_rs2_val <= rs2_val;
        out_imm     <= imm;
        out_rd      <= dec.use_rd ? rd : 5'd0;
        out_wr_en   <= wr_en;
        out_illegal <= dec.illegal;
      end else if (out_ready) begin
        out_valid <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_id_stage.sv
// Scoreboard bench for id_stage: directed vectors push expectations, a monitor checks transfers.
module tb_id_stage;

  logic        clk, reset;
  logic        in_valid, in_ready;
  logic [31:0] in_instr;
  logic [63:0] in_pc;
  logic [4:0]  rd1_idx, rd2_idx;
  logic [63:0] rd1_data, rd2_data;
  logic        wb_valid;
  logic [4:0]  wb_idx;
  logic [63:0] wb_data;
  logic        flush;
  logic        out_valid, out_ready;
  logic [63:0] out_pc, out_rs1_val, out_rs2_val, out_imm;
  logic [31:0] out_instr;
  logic [4:0]  out_rd;
  logic        out_wr_en, out_illegal;

  id_stage #(.XLEN(64)) dut (
    .clk(clk), .reset(reset),
    .in_valid(in_valid), .in_ready(in_ready), .in_instr(in_instr), .in_pc(in_pc),
    .rd1_idx(rd1_idx), .rd2_idx(rd2_idx), .rd1_data(rd1_data), .rd2_data(rd2_data),
    .wb_valid(wb_valid), .wb_idx(wb_idx), .wb_data(wb_data),
    .flush(flush),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_pc(out_pc), .out_instr(out_instr), .out_rs1_val(out_rs1_val),
    .out_rs2_val(out_rs2_val), .out_imm(out_imm), .out_rd(out_rd),
    .out_wr_en(out_wr_en), .out_illegal(out_illegal)
  );

  typedef struct {
    logic [63:0] pc;
    logic [31:0] instr;
    logic [63:0] rs1;
    logic [63:0] rs2;
    logic [63:0] imm;
    logic [4:0]  rd;
    logic        wr_en;
    logic        illegal;
    logic        chk_rs1;
    logic        chk_rs2;
    logic        chk_rd;
  } exp_t;

  exp_t q[$];
  int   total = 0;
  int   passed = 0;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] expv);
    total++;
    if (act === expv) passed++;
    else $display("FAIL %s: got %h expected %h", nm, act, expv);
  endtask

  function automatic exp_t mk(input logic [63:0] pc, input logic [31:0] instr,
                              input logic [63:0] rs1, input logic [63:0] rs2,
                              input logic [63:0] imm, input logic [4:0] rd,
                              input logic wr_en, input logic illegal,
                              input logic c1, input logic c2, input logic cr);
    exp_t e;
    e.pc = pc; e.instr = instr; e.rs1 = rs1; e.rs2 = rs2; e.imm = imm; e.rd = rd;
    e.wr_en = wr_en; e.illegal = illegal; e.chk_rs1 = c1; e.chk_rs2 = c2; e.chk_rd = cr;
    return e;
  endfunction

  // A transfer happens at the next rising edge whenever these hold at the falling edge.
  always @(negedge clk) begin
    if (!reset && !flush && out_valid && out_ready) begin
      if (q.size() == 0) begin
        total++;
        $display("FAIL unexpected_output: got pc %h, expected no output", out_pc);
      end else begin
        exp_t e;
        e = q.pop_front();
        chk("out_pc", out_pc, e.pc);
        chk("out_instr", {32'd0, out_instr}, {32'd0, e.instr});
        chk("out_imm", out_imm, e.imm);
        chk("out_wr_en", {63'd0, out_wr_en}, {63'd0, e.wr_en});
        chk("out_illegal", {63'd0, out_illegal}, {63'd0, e.illegal});
        if (e.chk_rs1) chk("out_rs1_val", out_rs1_val, e.rs1);
        if (e.chk_rs2) chk("out_rs2_val", out_rs2_val, e.rs2);
        if (e.chk_rd)  chk("out_rd", {59'd0, out_rd}, {59'd0, e.rd});
      end
    end
  end

  task automatic drive(input logic [31:0] instr, input logic [63:0] pc,
                       input logic [63:0] d1, input logic [63:0] d2);
    in_valid = 1'b1; in_instr = instr; in_pc = pc; rd1_data = d1; rd2_data = d2;
  endtask

  task automatic accept(input exp_t e, input string nm);
    int waited;
    waited = 0;
    #1;
    while (!in_ready && waited < 40) begin
      @(negedge clk);
      waited++;
    end
    if (!in_ready) begin
      total++;
      $display("FAIL %s_accept_timeout: in_ready %b, expected 1", nm, in_ready);
      in_valid = 1'b0;
      return;
    end
    @(posedge clk);
    q.push_back(e);
    #1 in_valid = 1'b0;
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time expired, expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    reset = 1'b1; in_valid = 1'b0; in_instr = '0; in_pc = '0;
    rd1_data = '0; rd2_data = '0; wb_valid = 1'b0; wb_idx = '0; wb_data = '0;
    flush = 1'b0; out_ready = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("reset_out_valid", {63'd0, out_valid}, 64'd0);
    chk("reset_in_ready", {63'd0, in_ready}, 64'd0);
    chk("reset_out_imm", out_imm, 64'd0);
    reset = 1'b0;

    // addi x5,x0,7
    drive(32'h00700293, 64'h1000, 64'hDEAD, 64'hBEEF);
    accept(mk(64'h1000, 32'h00700293, 64'd0, 64'd0, 64'd7, 5'd5, 1, 0, 1, 0, 1), "addi_x5");
    @(negedge clk);
    chk("sb_set_x5", {32'd0, dut.sb}, 64'h20);

    // add x6,x5,x5 blocked until x5 writes back, operands bypassed from wb_data
    drive(32'h00528333, 64'h1004, 64'h1111, 64'h2222);
    #1;
    chk("rd1_idx", {59'd0, rd1_idx}, 64'd5);
    chk("rd2_idx", {59'd0, rd2_idx}, 64'd5);
    repeat (3) begin
      @(negedge clk);
      chk("add_hazard_stall", {63'd0, in_ready}, 64'd0);
    end
    @(posedge clk); #1;
    wb_valid = 1'b1; wb_idx = 5'd5; wb_data = 64'h7;
    accept(mk(64'h1004, 32'h00528333, 64'h7, 64'h7, 64'd0, 5'd6, 1, 0, 1, 1, 1), "add_x6");
    wb_valid = 1'b0;
    @(negedge clk);
    chk("sb_after_add", {32'd0, dut.sb}, 64'h40);
    @(posedge clk); #1;

    // lui held by backpressure while the next store waits
    out_ready = 1'b0;
    drive(32'h12345437, 64'h1008, 64'd0, 64'd0);
    accept(mk(64'h1008, 32'h12345437, 64'd0, 64'd0, 64'h12345000, 5'd8, 1, 0, 0, 0, 1), "lui_x8");
    drive(32'hFE312C23, 64'h100C, 64'hAAAA, 64'hBBBB);
    repeat (3) begin
      @(negedge clk);
      chk("stall_in_ready", {63'd0, in_ready}, 64'd0);
      chk("stall_out_valid", {63'd0, out_valid}, 64'd1);
      chk("stall_out_pc", out_pc, 64'h1008);
      chk("stall_out_imm", out_imm, 64'h12345000);
    end
    @(posedge clk); #1;
    out_ready = 1'b1;
    accept(mk(64'h100C, 32'hFE312C23, 64'hAAAA, 64'hBBBB, 64'hFFFF_FFFF_FFFF_FFF8, 5'd0, 0, 0, 1, 1, 0), "sw");

    // beq x0,x0,-4
    drive(32'hFE000EE3, 64'h1010, 64'h5555, 64'h6666);
    accept(mk(64'h1010, 32'hFE000EE3, 64'd0, 64'd0, 64'hFFFF_FFFF_FFFF_FFFC, 5'd0, 0, 0, 1, 1, 0), "beq");
    @(negedge clk);
    chk("beq_sb_unchanged", {32'd0, dut.sb}, 64'h140);

    drive(32'h008000EF, 64'h1014, 64'd0, 64'd0);
    accept(mk(64'h1014, 32'h008000EF, 64'd0, 64'd0, 64'd8, 5'd1, 1, 0, 0, 0, 1), "jal_x1");
    drive(32'h00500013, 64'h1018, 64'h3333, 64'd0);
    accept(mk(64'h1018, 32'h00500013, 64'd0, 64'd0, 64'd5, 5'd0, 0, 0, 1, 0, 1), "addi_x0");
    drive(32'hFFFFF497, 64'h101C, 64'd0, 64'd0);
    accept(mk(64'h101C, 32'hFFFFF497, 64'd0, 64'd0, 64'hFFFF_FFFF_FFFF_F000, 5'd9, 1, 0, 0, 0, 1), "auipc_x9");
    drive(32'h0000007F, 64'h1020, 64'd0, 64'd0);
    accept(mk(64'h1020, 32'h0000007F, 64'd0, 64'd0, 64'd0, 5'd0, 0, 1, 0, 0, 0), "illegal");

    // second write to x5 accepted in the same cycle x5's old write retires: set wins
    drive(32'h00700293, 64'h1024, 64'd0, 64'd0);
    accept(mk(64'h1024, 32'h00700293, 64'd0, 64'd0, 64'd7, 5'd5, 1, 0, 1, 0, 1), "addi_x5_b");
    drive(32'h00300293, 64'h1028, 64'd0, 64'd0);
    wb_valid = 1'b1; wb_idx = 5'd5; wb_data = 64'h99;
    accept(mk(64'h1028, 32'h00300293, 64'd0, 64'd0, 64'd3, 5'd5, 1, 0, 1, 0, 1), "addi_x5_c");
    wb_valid = 1'b0;
    out_ready = 1'b0;
    @(negedge clk);
    chk("set_over_clear_sb", {32'd0, dut.sb}, 64'h362);

    // flush beats a simultaneous transfer and a pending accept
    @(posedge clk); #1;
    flush = 1'b1; out_ready = 1'b1;
    drive(32'h00100513, 64'h1030, 64'd0, 64'd0);
    @(negedge clk);
    chk("flush_in_ready", {63'd0, in_ready}, 64'd0);
    @(posedge clk); #1;
    flush = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
    void'(q.pop_back());
    @(negedge clk);
    chk("flush_out_valid", {63'd0, out_valid}, 64'd0);
    chk("flush_sb", {32'd0, dut.sb}, 64'd0);

    // reset while stalled
    drive(32'h00100513, 64'h102C, 64'd0, 64'd0);
    accept(mk(64'h102C, 32'h00100513, 64'd0, 64'd0, 64'd1, 5'd10, 1, 0, 1, 0, 1), "addi_x10");
    @(posedge clk); #3;
    reset = 1'b1;
    #1;
    chk("rst_out_valid", {63'd0, out_valid}, 64'd0);
    chk("rst_out_pc", out_pc, 64'd0);
    chk("rst_out_imm", out_imm, 64'd0);
    chk("rst_out_rd", {59'd0, out_rd}, 64'd0);
    chk("rst_out_wr_en", {63'd0, out_wr_en}, 64'd0);
    chk("rst_in_ready", {63'd0, in_ready}, 64'd0);
    chk("rst_sb", {32'd0, dut.sb}, 64'd0);
    void'(q.pop_back());
    @(negedge clk);
    reset = 1'b0; out_ready = 1'b1;
    drive(32'hFFF00593, 64'h2000, 64'd0, 64'd0);
    #1;
    chk("first_accept_after_reset", {63'd0, in_ready}, 64'd1);
    accept(mk(64'h2000, 32'hFFF00593, 64'd0, 64'd0, 64'hFFFF_FFFF_FFFF_FFFF, 5'd11, 1, 0, 1, 0, 1), "addi_x11");
    repeat (3) @(negedge clk);
    chk("queue_drained", q.size(), 64'd0);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
